// File: rtl/ram_sweep_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_sweep_if
//  Description : Bus and program-load signal bundle for ram_sweep. The
//                master side (CPU bus / loader) drives requests; the slave
//                side (the RAM) returns status strobes. The tri-stated read
//                data stays a plain port on the RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_sweep_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  we;
   logic                  oe;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  data_valid;
   logic                  busy;
   logic                  clear_req;
   logic                  prog_we;
   logic [ADDR_WIDTH-1:0] prog_addr;
   logic [DATA_WIDTH-1:0] prog_data;
   logic                  prog_ack;
   logic                  wr_dropped;

   modport master (
      output we, oe, address, data_in, clear_req, prog_we, prog_addr, prog_data,
      input  data_valid, busy, prog_ack, wr_dropped
   );

   modport slave (
      input  we, oe, address, data_in, clear_req, prog_we, prog_addr, prog_data,
      output data_valid, busy, prog_ack, wr_dropped
   );
endinterface
`default_nettype wire

// File: rtl/ram_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : ram_sweep
//  Description : Single-port synchronous RAM with a hardware clear sweep
//                after reset or on request, a side-channel program-load port
//                with acknowledge, a registered read-valid strobe and defined
//                collision behaviour. Read data is driven onto the shared bus
//                only while data_valid is high.
//                Optional build macro RAM_BYPASS_EN: same-cycle read and
//                write to one address returns the data being written
//                (write-first); otherwise the old contents are returned.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_sweep #(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    ADDR_WIDTH  = 4,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  wire                   clk,
   input  wire                   reset_n,
   ram_sweep_if.slave            bus,
   output wire [DATA_WIDTH-1:0]  data_out
);

   localparam int                  c_depth    = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] c_last_ptr = (ADDR_WIDTH+1)'(c_depth - 1);
   localparam logic [ADDR_WIDTH:0] c_ptr_one  = (ADDR_WIDTH+1)'(1);

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   // One extra bit so the final sweep address is reached without wrapping.
   logic [ADDR_WIDTH:0]   r_ptr;
   logic [ADDR_WIDTH:0]   w_ptr_nxt;

   logic [DATA_WIDTH-1:0] r_mem [c_depth];

   logic                  w_mem_we;
   logic [ADDR_WIDTH-1:0] w_mem_addr;
   logic [DATA_WIDTH-1:0] w_mem_data;
   logic                  w_rd;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic                  w_ack_nxt;
   logic                  w_drop_nxt;

   logic [DATA_WIDTH-1:0] r_data_q;
   logic                  r_valid;
   logic                  r_prog_ack;
   logic                  r_wr_dropped;

   // State and sweep pointer register; reset restarts the sweep from word 0.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_CLEAR;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   // Next state plus arbitration of the single write port between sweep,
   // program port and bus; the program port beats a simultaneous bus write.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_mem_we    = 1'b0;
      w_mem_addr  = r_ptr[ADDR_WIDTH-1:0];
      w_mem_data  = CLEAR_VALUE;
      w_rd        = 1'b0;
      w_ack_nxt   = 1'b0;
      w_drop_nxt  = 1'b0;
      case (r_state)
         S_CLEAR: begin
            w_mem_we  = reset_n;
            w_ptr_nxt = r_ptr + c_ptr_one;
            if (r_ptr == c_last_ptr) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.clear_req) begin
               w_state_nxt = S_CLEAR;
               w_ptr_nxt   = '0;
            end else begin
               w_rd = bus.oe;
               if (bus.prog_we) begin
                  w_mem_we   = reset_n;
                  w_mem_addr = bus.prog_addr;
                  w_mem_data = bus.prog_data;
                  w_ack_nxt  = 1'b1;
                  w_drop_nxt = bus.we;
               end else if (bus.we) begin
                  w_mem_we   = reset_n;
                  w_mem_addr = bus.address;
                  w_mem_data = bus.data_in;
               end
            end
         end
         default: begin
            w_state_nxt = S_CLEAR;
            w_ptr_nxt   = '0;
         end
      endcase
   end

`ifdef RAM_BYPASS_EN
   // Write-first: a read of the word being written returns the new data.
   always_comb begin
      w_rd_data = r_mem[bus.address];
      if (w_mem_we && (w_mem_addr == bus.address)) begin
         w_rd_data = w_mem_data;
      end
   end
`else
   // Read-first: a read always returns the contents before this edge.
   always_comb begin
      w_rd_data = r_mem[bus.address];
   end
`endif

   // Storage array; no reset, contents are initialised by the clear sweep.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_data;
      end
   end

   // Registered read data, valid strobe and one-cycle status pulses.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_data_q     <= '0;
         r_valid      <= 1'b0;
         r_prog_ack   <= 1'b0;
         r_wr_dropped <= 1'b0;
      end else begin
         r_valid      <= w_rd;
         r_prog_ack   <= w_ack_nxt;
         r_wr_dropped <= w_drop_nxt;
         if (w_rd) begin
            r_data_q <= w_rd_data;
         end
      end
   end

   assign bus.busy       = (r_state == S_CLEAR);
   assign bus.data_valid = r_valid;
   assign bus.prog_ack   = r_prog_ack;
   assign bus.wr_dropped = r_wr_dropped;
   // Bus driver enabled only by the registered valid strobe.
   assign data_out       = r_valid ? r_data_q : {DATA_WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_ram_sweep.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ram_sweep
//  Description : Directed, table-driven bench for ram_sweep (8x16 default
//                instance) plus a 16x64 instance with CLEAR_VALUE 0xBEEF for
//                the reset-mid-sweep sequence. Honours RAM_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_sweep;

   localparam int DW  = 8;
   localparam int AW  = 4;
   localparam int DW2 = 16;
   localparam int AW2 = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   logic reset_n2;

   ram_sweep_if #(.DATA_WIDTH(DW),  .ADDR_WIDTH(AW))  bus  ();
   ram_sweep_if #(.DATA_WIDTH(DW2), .ADDR_WIDTH(AW2)) bus2 ();
   wire [DW-1:0]  data_out;
   wire [DW2-1:0] data_out2;

   ram_sweep #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_VALUE(8'h00)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus.slave),
      .data_out (data_out)
   );

   ram_sweep #(.DATA_WIDTH(DW2), .ADDR_WIDTH(AW2), .CLEAR_VALUE(16'hBEEF)) dut2 (
      .clk      (clk),
      .reset_n  (reset_n2),
      .bus      (bus2.slave),
      .data_out (data_out2)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          we;
      logic          oe;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
      logic          pwe;
      logic [AW-1:0] paddr;
      logic [DW-1:0] pdata;
      logic          ev;
      logic [DW-1:0] ed;
      logic          eack;
      logic          edrop;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic we, input logic oe, input logic [AW-1:0] addr,
                      input logic [DW-1:0] din, input logic pwe, input logic [AW-1:0] paddr,
                      input logic [DW-1:0] pdata, input logic ev, input logic [DW-1:0] ed,
                      input logic eack, input logic edrop);
      vt.push_back('{we, oe, addr, din, pwe, paddr, pdata, ev, ed, eack, edrop});
   endtask

   task automatic idle1();
      bus.we = 1'b0; bus.oe = 1'b0; bus.address = '0; bus.data_in = '0;
      bus.clear_req = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
   endtask

   task automatic idle2();
      bus2.we = 1'b0; bus2.oe = 1'b0; bus2.address = '0; bus2.data_in = '0;
      bus2.clear_req = 1'b0; bus2.prog_we = 1'b0; bus2.prog_addr = '0; bus2.prog_data = '0;
   endtask

   // Counts consecutive busy samples (one per cycle) from the current
   // negedge; optionally holds bus writes and program writes asserted.
   task automatic count_busy1(input logic poke, output int n);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         if (!bus.busy) break;
         n++;
         chk("ack_during_busy", 32'(bus.prog_ack), 32'd0);
         chk("drop_during_busy", 32'(bus.wr_dropped), 32'd0);
         bus.we = poke; bus.address = 4'd15; bus.data_in = 8'h99;
         bus.prog_we = poke; bus.prog_addr = 4'd15; bus.prog_data = 8'h98;
         @(posedge clk); @(negedge clk);
      end
      idle1();
   endtask

   task automatic count_busy2(output int n);
      n = 0;
      for (int i = 0; i < 300; i++) begin
         if (!bus2.busy) break;
         n++;
         @(posedge clk); @(negedge clk);
      end
   endtask

   task automatic read1(input logic [AW-1:0] a, input logic [DW-1:0] e, input string name);
      bus.oe = 1'b1; bus.address = a;
      @(posedge clk); @(negedge clk);
      bus.oe = 1'b0;
      chk({name, "_valid"}, 32'(bus.data_valid), 32'd1);
      chk(name, 32'(data_out), 32'(e));
   endtask

   `ifdef RAM_BYPASS_EN
   localparam logic [DW-1:0] c_col7 = 8'hF0;
   localparam logic [DW-1:0] c_col3 = 8'h3C;
   `else
   localparam logic [DW-1:0] c_col7 = 8'h0F;
   localparam logic [DW-1:0] c_col3 = 8'hA5;
   `endif

   initial begin
      int n;
      reset_n  = 1'b0;
      reset_n2 = 1'b0;
      idle1();
      idle2();

      // Reset: two cycles low, outputs at their reset values.
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd1);
      chk("rst_valid", 32'(bus.data_valid), 32'd0);
      chk("rst_ack", 32'(bus.prog_ack), 32'd0);
      chk("rst_drop", 32'(bus.wr_dropped), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      count_busy1(1'b0, n);
      chk("reset_sweep_len", 32'(n), 32'd16);

      // Vector table: back-to-back reads of the cleared array, then
      // program load, conflicts and collisions.
      for (int i = 0; i < 16; i++) add(0, 1, 4'(i), 8'h00, 0, 4'h0, 8'h00, 1, 8'h00, 0, 0);
      add(0, 0, 4'h0, 8'h00, 1, 4'h3, 8'hA5, 0, 8'h00, 1, 0);   // program load
      add(0, 1, 4'h3, 8'h00, 0, 4'h0, 8'h00, 1, 8'hA5, 0, 0);   // read it back
      add(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 0, 8'h00, 0, 0);   // bus released
      add(1, 0, 4'h5, 8'h11, 1, 4'h5, 8'h22, 0, 8'h00, 1, 1);   // write conflict
      add(0, 1, 4'h5, 8'h00, 0, 4'h0, 8'h00, 1, 8'h22, 0, 0);
      add(1, 0, 4'h9, 8'h66, 1, 4'hA, 8'h77, 0, 8'h00, 1, 1);   // conflict, diff addr
      add(0, 1, 4'h9, 8'h00, 0, 4'h0, 8'h00, 1, 8'h00, 0, 0);
      add(0, 1, 4'hA, 8'h00, 0, 4'h0, 8'h00, 1, 8'h77, 0, 0);
      add(1, 0, 4'h7, 8'h0F, 0, 4'h0, 8'h00, 0, 8'h00, 0, 0);   // mem[7]=0F
      add(1, 1, 4'h7, 8'hF0, 0, 4'h0, 8'h00, 1, c_col7, 0, 0);  // bus collision
      add(0, 1, 4'h7, 8'h00, 0, 4'h0, 8'h00, 1, 8'hF0, 0, 0);
      add(0, 1, 4'h3, 8'h00, 1, 4'h3, 8'h3C, 1, c_col3, 1, 0);  // prog collision
      add(0, 1, 4'h3, 8'h00, 0, 4'h0, 8'h00, 1, 8'h3C, 0, 0);
      add(1, 0, 4'hF, 8'h55, 0, 4'h0, 8'h00, 0, 8'h00, 0, 0);
      add(0, 1, 4'hF, 8'h00, 0, 4'h0, 8'h00, 1, 8'h55, 0, 0);

      foreach (vt[i]) begin
         bus.we = vt[i].we; bus.oe = vt[i].oe; bus.address = vt[i].addr;
         bus.data_in = vt[i].din; bus.prog_we = vt[i].pwe;
         bus.prog_addr = vt[i].paddr; bus.prog_data = vt[i].pdata;
         @(posedge clk); @(negedge clk);
         chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'd0);
         chk($sformatf("v%0d_valid", i), 32'(bus.data_valid), 32'(vt[i].ev));
         if (vt[i].ev) chk($sformatf("v%0d_data", i), 32'(data_out), 32'(vt[i].ed));
         chk($sformatf("v%0d_ack", i), 32'(bus.prog_ack), 32'(vt[i].eack));
         chk($sformatf("v%0d_drop", i), 32'(bus.wr_dropped), 32'(vt[i].edrop));
      end
      idle1();

      // clear_req with a same-cycle write that must be discarded, writes
      // held during the sweep, then everything reads CLEAR_VALUE.
      bus.clear_req = 1'b1; bus.we = 1'b1; bus.address = 4'hF; bus.data_in = 8'h77;
      @(posedge clk); @(negedge clk);
      idle1();
      chk("clr_ack", 32'(bus.prog_ack), 32'd0);
      count_busy1(1'b1, n);
      chk("clear_sweep_len", 32'(n), 32'd16);
      read1(4'hF, 8'h00, "clr_rd15");
      read1(4'h3, 8'h00, "clr_rd3");
      @(posedge clk); @(negedge clk);
      chk("clr_released", 32'(bus.data_valid), 32'd0);

      // Reset mid-read drops valid.
      bus.oe = 1'b1; bus.address = 4'h0;
      @(posedge clk); @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("rst_midread_valid", 32'(bus.data_valid), 32'd0);
      idle1();
      reset_n = 1'b1;

      // Wide instance: full sweep, dirty two words, reset at sweep cycle 20.
      reset_n2 = 1'b1;
      count_busy2(n);
      chk("w_first_sweep_len", 32'(n), 32'd64);
      bus2.we = 1'b1; bus2.address = 6'd63; bus2.data_in = 16'h1234;
      @(posedge clk); @(negedge clk);
      bus2.address = 6'd10;
      @(posedge clk); @(negedge clk);
      idle2();
      reset_n2 = 1'b0;
      repeat (2) @(negedge clk);
      reset_n2 = 1'b1;
      repeat (20) @(negedge clk);
      chk("w_busy_at20", 32'(bus2.busy), 32'd1);
      reset_n2 = 1'b0;
      repeat (2) @(negedge clk);
      reset_n2 = 1'b1;
      count_busy2(n);
      chk("w_restart_sweep_len", 32'(n), 32'd64);
      for (int i = 0; i < 64; i++) begin
         bus2.oe = 1'b1; bus2.address = 6'(i);
         @(posedge clk); @(negedge clk);
         chk($sformatf("w_rd%0d_valid", i), 32'(bus2.data_valid), 32'd1);
         chk($sformatf("w_rd%0d", i), 32'(data_out2), 32'hBEEF);
      end
      idle2();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/ram_sweep.md
# ram_sweep

Parametrised single-port synchronous RAM for the SAP-1.5 datapath. It generalises the 16×8 bus RAM in width and depth. It adds four things: a hardware clear sweep after reset or on request, a side-channel program-load port with an acknowledge, a registered read-valid strobe, and defined collision behaviour. The block sits on the shared CPU bus behind the MAR (address) and drives the bus only while its read data is valid.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH words
- CLEAR_VALUE, 0, DATA_WIDTH-bit value written to every word by the clear sweep
---
- clk  in  1  system clock, all activity on rising edge
- reset_n  in  1  synchronous, active-low reset
- we  in  1  bus write enable (RI)
- oe  in  1  bus read enable (RO)
- address  in  ADDR_WIDTH  bus address
- data_in  in  DATA_WIDTH  bus write data
- data_out  out  DATA_WIDTH  read data; high-Z unless data_valid=1
- data_valid  out  1  registered read data present on data_out
- busy  out  1  clear sweep in progress; bus and program ports ignored
- clear_req  in  1  start a clear sweep (sampled in RUN only)
- prog_we  in  1  program-port write request
- prog_addr  in  ADDR_WIDTH  program-port address
- prog_data  in  DATA_WIDTH  program-port data
- prog_ack  out  1  one-cycle pulse acknowledging an accepted prog write
- wr_dropped  out  1  one-cycle pulse: bus write lost to a program write

## Operation
- FSM with two states, CLEAR and RUN.
- reset_n=0 → state CLEAR and sweep pointer 0. All registered outputs go to 0: data_valid=0, data_out=Z, prog_ack=0, wr_dropped=0. busy=1 (busy is a state decode).
- CLEAR:
  - Writes CLEAR_VALUE to mem[ptr] each cycle, then ptr+1.
  - After writing ptr=DEPTH-1 → RUN. The sweep takes exactly DEPTH cycles.
  - we, oe, prog_we and clear_req are ignored. No ack or valid is produced.
- RUN: busy=0.
  - clear_req=1 → ptr=0 and state CLEAR on the next edge. Any bus or program access in the same cycle is discarded.
  - prog_we=1 → mem[prog_addr]←prog_data. prog_ack=1 on the following cycle.
  - we=1 and prog_we=0 → mem[address]←data_in.
  - we=1 and prog_we=1 → the program write wins. The bus write is discarded and wr_dropped=1 on the following cycle.
  - oe=1 → data_q←mem[address] and data_valid=1 on the next cycle; otherwise data_valid=0 on the next cycle.
- Read/write to the same address in the same cycle (either write source): read-first, i.e. old data is returned, unless the Configuration macro below is defined.
- Address arithmetic is unsigned. The sweep pointer is ADDR_WIDTH+1 bits wide so that termination is detected without wrap.
- Reset asserted mid-sweep restarts the sweep at 0. Reset asserted mid-read drops data_valid and releases the bus.

## Timing
- Read latency is 1 cycle. Assert oe at edge N with address A; data_out=mem[A] and data_valid=1 during cycle N+1.
- Back-to-back oe gives one word per cycle, and data_valid stays high throughout.
- Write latency is 1 cycle. A word written at edge N is readable by an oe sampled at edge N+1.
- prog_ack and wr_dropped are single-cycle pulses that fire one cycle after the request edge. They are never asserted while busy=1.
- Following reset release there are DEPTH cycles with busy=1. The first access is accepted at the edge where busy has just read 0.
- The data_out tri-state enable is data_valid (registered), never a combinational function of oe.

## Configuration
- RAM_BYPASS_EN:
  - Defined: same-cycle read and write to the same address is write-first, so the read returns the data being written. If both write sources are active, it returns the winning (program) data.
  - Undefined: read-first, returning the pre-write contents.
  - Both builds are otherwise identical.

## Test plan
- Reset sweep: hold reset_n=0 for 2 cycles, then release. Required: busy=1 for exactly 16 cycles, then 0. Reading addresses 0–15 returns 0x00 with data_valid=1 one cycle after each oe.
- Program load then bus read: prog_we with addr 3 and data 0xA5 → prog_ack=1 next cycle. Then oe with address 3 → data_out=0xA5 and data_valid=1 one cycle later; data_out=Z when oe drops.
- Write conflict: same cycle, we=1 (addr 5, 0x11) and prog_we=1 (addr 5, 0x22) → prog_ack=1 and wr_dropped=1. A subsequent read of address 5 returns 0x22.
- Collision: mem[7]=0x0F, then we=1 (addr 7, 0xF0) with oe=1 (addr 7). Required: returns 0x0F without RAM_BYPASS_EN and 0xF0 with it. mem[7]=0xF0 afterward in both builds.
- clear_req mid-operation: write 0x55 to address 15, pulse clear_req → busy=1 for 16 cycles. Reading address 15 afterwards returns CLEAR_VALUE. A we asserted during busy has no effect.
- Reset mid-sweep and parameter reuse: with DATA_WIDTH=16, ADDR_WIDTH=6 and CLEAR_VALUE=0xBEEF, assert reset_n=0 at sweep cycle 20. Required: after release, busy lasts a full 64 cycles and every word reads 0xBEEF.
